serial_alu_seq: RTL and testbench
=================================

# serial_alu_seq

Bit-serial ALU sequencer that drives one instance of the team's `alu1Bit` slice for one bit per clock. It accepts a WIDTH-bit operation and walks both operands LSB-first through the slice. It registers the slice's carry between bits and assembles the WIDTH-bit result and flags. It sits between the datapath operand registers and the single-bit ALU slice, trading latency for area in the lab datapath.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- ALUOp  input  4  operation code, same encoding as `alu1Bit`; captured on accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; result/flags valid and newly updated.
- result  output  WIDTH  registered result; holds until the next completion.
- zero  output  1  result == 0.
- carry  output  1  final carry out; add/sub only, else 0.
- overflow  output  1  signed overflow; add/sub only, else 0.

## Operation
- Supported opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a + ~b + 1)
  - 1100 NOR (~a & ~b)
  - 1101 NAND (~a | ~b)
  - All other codes yield result 0, zero 1, carry 0, overflow 0.
- States are IDLE, RUN and DONE.
- IDLE, start=1:
  - Latch a and b into shift registers, and latch ALUOp.
  - Bit counter = 0.
  - Carry register = 1 if ALUOp==0110, else 0.
  - Go to RUN.
- RUN, each cycle:
  - Slice inputs are the shift-register LSBs, the carry register and the latched ALUOp.
  - Shift the slice result bit into the result shift register from the MSB end, so the register holds the full word after WIDTH bits.
  - Carry register <= slice carryOut.
  - Shift operands right by one; counter += 1.
  - On the bit where counter == WIDTH-1, save the carry-in of that MSB bit for the overflow calculation.
- RUN exit, after processing bit WIDTH-1:
  - Load result, zero and flags into the output registers.
  - For ADD/SUB: carry = final carryOut; overflow = MSB carry-in XOR final carryOut.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; there is no queuing.
- a, b and ALUOp may change freely after acceptance without affecting the operation in flight.
- Async reset, in any state:
  - state IDLE; busy 0, done 0; result 0, zero 1, carry 0, overflow 0.
  - All internal shift registers, counter and carry cleared.
  - An operation in flight is abandoned and produces no done.

## Timing
- Start accepted at rising edge E0, when start=1 in IDLE.
- busy is high from E0 through E_WIDTH.
- Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- done is high in the cycle after E_WIDTH; new result and flags are visible in that same cycle.
- Latency is WIDTH+1 cycles from accepting edge to done.
- Throughput is one operation per WIDTH+2 cycles. The earliest next start is sampled at the edge that ends the DONE cycle plus one, i.e. in IDLE.
- start held high continuously gives back-to-back operations with exactly one IDLE cycle between done and the next busy.
- Outputs are fully registered, with no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, ADD, a=0x05, b=0x03, start pulse:
  - busy for 8 cycles, then done.
  - result 0x08, zero 0, carry 0, overflow 0.
- WIDTH=8, SUB, a=0x03, b=0x05:
  - result 0xFE, carry 0, overflow 0.
  - Then a=0x05, b=0x05 gives result 0x00, zero 1, carry 1.
- WIDTH=8, ADD, a=0x7F, b=0x01 → result 0x80, overflow 1, carry 0.
- WIDTH=8, ADD, a=0xFF, b=0x01 → result 0x00, carry 1, overflow 0, zero 1.
- WIDTH=8, logic ops with a=0xF0, b=0x3C:
  - AND 0x30
  - OR 0xFC
  - NOR 0x03
  - NAND 0xCF
  - opcode 0111 gives 0x00 with zero 1.
- Control corner cases:
  - start pulsed again mid-RUN with different operands: ignored, original result delivered.
  - rst asserted at bit 4 of a run: outputs immediately go to reset values and no done pulse follows.
  - A fresh start after reset completes correctly.
  - start held high for three operations: each done is followed by one IDLE cycle before busy rises again.

Source files
------------

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: walks two WIDTH-bit operands LSB-first through a single-bit ALU
// slice, one bit per clock, and registers the assembled result and flags.
module serial_alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpNand = 4'b1101;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

    logic             s_a, s_b, s_bx, s_res, s_cout, is_arith;
    logic [WIDTH-1:0] res_shifted;

    // Single-bit ALU slice
    always_comb begin
        s_a    = a_q[0];
        s_b    = b_q[0];
        s_bx   = (op_q == OpSub) ? ~s_b : s_b;
        s_res  = 1'b0;
        s_cout = 1'b0;
        case (op_q)
            OpAnd:  s_res = s_a & s_b;
            OpOr:   s_res = s_a | s_b;
            OpAdd, OpSub: begin
                s_res  = s_a ^ s_bx ^ cin_q;
                s_cout = (s_a & s_bx) | (cin_q & (s_a ^ s_bx));
            end
            OpNor:  s_res = ~s_a & ~s_b;
            OpNand: s_res = ~s_a | ~s_b;
            default: s_res = 1'b0;
        endcase
    end

    assign is_arith    = (op_q == OpAdd) || (op_q == OpSub);
    assign res_shifted = {s_res, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        cin_d    = cin_q;
        res_d    = res_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = ALUOp;
                    cnt_d   = '0;
                    cin_d   = (ALUOp == OpSub);
                    res_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d = res_shifted;
                cin_d = s_cout;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    // On the MSB bit, cin_q is the carry into the sign position
                    result_d = res_shifted;
                    zero_d   = (res_shifted == '0);
                    carry_d  = is_arith & s_cout;
                    ovf_d    = is_arith & (cin_q ^ s_cout);
                    cnt_d    = '0;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            cin_q    <= 1'b0;
            res_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            cin_q    <= cin_d;
            res_q    <= res_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq at WIDTH=8: directed vectors queue expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_alu_seq;

    localparam int unsigned W = 8;

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpNand = 4'b1101;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   alu_op;
    logic         busy, done, zero, carry, overflow;
    logic [W-1:0] result;

    exp_t sb[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_done  = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .ALUOp    (alu_op),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [W-1:0] r, input logic c, input logic o);
        exp_t x;
        x.r = r;
        x.z = (r == '0);
        x.c = c;
        x.o = o;
        sb.push_back(x);
    endtask

    // Returns at the negedge after the accepting edge
    task automatic start_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a      = av;
        b      = bv;
        alu_op = op;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_busy);
        int n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, exp_busy);
        check({tag, "_done"}, {31'b0, done}, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 0);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] r, input logic c,
                       input logic o);
        push(r, c, o);
        start_op(op, av, bv);
        wait_done(tag, W);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"},   {24'b0, result},     0);
        check({tag, "_zero"},     {31'b0, zero},       1);
        check({tag, "_carry"},    {31'b0, carry},      0);
        check({tag, "_overflow"}, {31'b0, overflow},   0);
        check({tag, "_busy"},     {31'b0, busy},       0);
        check({tag, "_done"},     {31'b0, done},       0);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 result=0x%0h, want no pending op",
                         result);
            end else begin
                mon_e = sb.pop_front();
                check("mon_result",   {24'b0, result},   {24'b0, mon_e.r});
                check("mon_zero",     {31'b0, zero},     {31'b0, mon_e.z});
                check("mon_carry",    {31'b0, carry},    {31'b0, mon_e.c});
                check("mon_overflow", {31'b0, overflow}, {31'b0, mon_e.o});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1, "watchdog");
    end

    logic [3:0]   bb_op[3];
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];

    initial begin
        int saved;
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        alu_op = '0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        run("add_5_3",   OpAdd,  8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
        run("sub_3_5",   OpSub,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
        run("sub_5_5",   OpSub,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
        run("add_7f_1",  OpAdd,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run("add_ff_1",  OpAdd,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run("and",       OpAnd,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
        run("or",        OpOr,   8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0);
        run("nor",       OpNor,  8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0);
        run("nand",      OpNand, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0);
        run("illegal",   4'b0111, 8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0);

        // Second start mid-RUN must be ignored
        push(8'h30, 1'b0, 1'b0);
        start_op(OpAdd, 8'h10, 8'h20);
        repeat (3) @(negedge clk);
        a      = 8'hFF;
        b      = 8'hFF;
        alu_op = OpAnd;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done("midrun", W - 4);

        // Abort at bit 4
        start_op(OpAdd, 8'h12, 8'h34);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        saved = n_done;
        repeat (15) @(negedge clk);
        check("abort_no_done", n_done, saved);

        run("post_rst_sub", OpSub, 8'h40, 8'h01, 8'h3F, 1'b1, 1'b0);

        // start held high: three back-to-back operations
        bb_op[0] = OpAdd; bb_a[0] = 8'h01; bb_b[0] = 8'h01; push(8'h02, 1'b0, 1'b0);
        bb_op[1] = OpOr;  bb_a[1] = 8'h0F; bb_b[1] = 8'hA0; push(8'hAF, 1'b0, 1'b0);
        bb_op[2] = OpSub; bb_a[2] = 8'h80; bb_b[2] = 8'h01; push(8'h7F, 1'b1, 1'b1);
        @(negedge clk);
        a      = bb_a[0];
        b      = bb_b[0];
        alu_op = bb_op[0];
        start  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!done && n < 40) begin
                n++;
                @(negedge clk);
            end
            check("b2b_done", {31'b0, done}, 1);
            @(negedge clk);
            check("b2b_idle_gap", {31'b0, busy}, 0);
            if (i < 2) begin
                a      = bb_a[i+1];
                b      = bb_b[i+1];
                alu_op = bb_op[i+1];
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("b2b_restart", {31'b0, busy}, (i < 2) ? 1 : 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
